// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control interface: CtrlFunc codes, branch codes,
// flag values and the issue-sequencer state encoding.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_XOR   = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_CMP   = 4'b0101;
    localparam logic [3:0] OP_NOT   = 4'b0110;
    localparam logic [3:0] OP_SHL16 = 4'b0111;
    localparam logic [3:0] OP_MUL   = 4'b1000;
    localparam logic [3:0] OP_BEQ   = 4'b1001;
    localparam logic [3:0] OP_BLT   = 4'b1010;
    localparam logic [3:0] OP_BGT   = 4'b1011;
    localparam logic [3:0] OP_NOP   = 4'b1111;

    localparam logic [1:0] F_POS  = 2'b00;
    localparam logic [1:0] F_ZERO = 2'b01;
    localparam logic [1:0] F_NEG  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_EXEC     = 2'b01,
        ST_MUL_WAIT = 2'b10,
        ST_DONE     = 2'b11
    } state_e;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op <= OP_MUL);
    endfunction

    function automatic logic is_branch_op(input logic [3:0] op);
        return (op == OP_BEQ) || (op == OP_BLT) || (op == OP_BGT);
    endfunction

endpackage

// File: rtl/alu_issue_seq_if.sv
// Decode handshake, ALU drive/return and writeback/branch outputs of the issue sequencer.
interface alu_issue_seq_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [3:0]   alu_func;
    logic [W-1:0] alu_result;
    logic [1:0]   alu_flags;
    logic         wb_valid;
    logic         wb_en;
    logic [W-1:0] wb_data;
    logic [1:0]   flags;
    logic         br_valid;
    logic         br_taken;
    logic         illegal;

    modport slave (
        input  in_valid, in_op, in_a, in_b, alu_result, alu_flags,
        output in_ready, alu_a, alu_b, alu_func, wb_valid, wb_en, wb_data,
               flags, br_valid, br_taken, illegal
    );

    modport master (
        output in_valid, in_op, in_a, in_b, alu_result, alu_flags,
        input  in_ready, alu_a, alu_b, alu_func, wb_valid, wb_en, wb_data,
               flags, br_valid, br_taken, illegal
    );
endinterface

// File: rtl/alu_issue_seq_br_cond_eval.sv
// Branch condition evaluation from the architectural flag register.
module br_cond_eval
    import alu_pkg::*;
(
    input  logic [3:0] op_i,
    input  logic [1:0] flags_i,
    output logic       taken_o
);

    // Decode branch opcode against the stored flags
    always_comb begin
        taken_o = 1'b0;
        case (op_i)
            OP_BEQ:  taken_o = (flags_i == F_ZERO);
            OP_BLT:  taken_o = (flags_i == F_NEG);
            OP_BGT:  taken_o = (flags_i == F_POS);
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_issue_seq.sv
// ALU issue sequencer: accepts one decoded op at a time, holds ALU inputs for the op
// latency, then pulses writeback, branch resolution or illegal for one cycle.
module alu_issue_seq
    import alu_pkg::*;
#(
    parameter int W       = 32,
    parameter int MUL_LAT = 3
) (
    input logic            clk,
    input logic            rst_n,
    alu_issue_seq_if.slave bus
);

    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d, wb_data_q, wb_data_d;
    logic [3:0]       func_q, func_d;
    logic [1:0]       flags_q, flags_d;
    logic             in_ready_q, in_ready_d;
    logic             wb_valid_q, wb_valid_d, wb_en_q, wb_en_d;
    logic             br_valid_q, br_valid_d, br_taken_q, br_taken_d;
    logic             illegal_q, illegal_d;
    logic             taken_s;

    br_cond_eval u_br_cond_eval (
        .op_i    (bus.in_op),
        .flags_i (flags_q),
        .taken_o (taken_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && is_alu_op(bus.in_op)) begin
                    state_d = ST_EXEC;
                end else if (bus.in_valid) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (func_q == OP_MUL) begin
                    state_d = ST_MUL_WAIT;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_MUL_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_MUL_WAIT;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values; pulses are set on the edge entering DONE
    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        func_d     = func_q;
        cnt_d      = cnt_q;
        wb_data_d  = wb_data_q;
        flags_d    = flags_q;
        wb_valid_d = 1'b0;
        wb_en_d    = 1'b0;
        br_valid_d = 1'b0;
        br_taken_d = 1'b0;
        illegal_d  = 1'b0;
        in_ready_d = (state_d == ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && is_alu_op(bus.in_op)) begin
                    a_d    = bus.in_a;
                    b_d    = bus.in_b;
                    func_d = bus.in_op;
                end else if (bus.in_valid && is_branch_op(bus.in_op)) begin
                    br_valid_d = 1'b1;
                    br_taken_d = taken_s;
                end else if (bus.in_valid) begin
                    illegal_d = 1'b1;
                end else begin
                    func_d = OP_NOP;
                end
            end
            ST_EXEC: begin
                if (func_q == OP_MUL) begin
                    cnt_d = CNT_W'(MUL_LAT - 1);
                end else begin
                    wb_valid_d = 1'b1;
                    wb_en_d    = (func_q != OP_CMP);
                    wb_data_d  = bus.alu_result;
                    func_d     = OP_NOP;
                    if (func_q == OP_CMP) begin
                        flags_d = bus.alu_flags;
                    end else begin
                        flags_d = flags_q;
                    end
                end
            end
            ST_MUL_WAIT: begin
                if (cnt_q == '0) begin
                    wb_valid_d = 1'b1;
                    wb_en_d    = 1'b1;
                    wb_data_d  = bus.alu_result;
                    func_d     = OP_NOP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: func_d = OP_NOP;
            default: func_d = OP_NOP;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            func_q     <= OP_NOP;
            cnt_q      <= '0;
            wb_data_q  <= '0;
            flags_q    <= F_POS;
            in_ready_q <= 1'b1;
            wb_valid_q <= 1'b0;
            wb_en_q    <= 1'b0;
            br_valid_q <= 1'b0;
            br_taken_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            func_q     <= func_d;
            cnt_q      <= cnt_d;
            wb_data_q  <= wb_data_d;
            flags_q    <= flags_d;
            in_ready_q <= in_ready_d;
            wb_valid_q <= wb_valid_d;
            wb_en_q    <= wb_en_d;
            br_valid_q <= br_valid_d;
            br_taken_q <= br_taken_d;
            illegal_q  <= illegal_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.alu_a    = a_q;
    assign bus.alu_b    = b_q;
    assign bus.alu_func = func_q;
    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_en    = wb_en_q;
    assign bus.wb_data  = wb_data_q;
    assign bus.flags    = flags_q;
    assign bus.br_valid = br_valid_q;
    assign bus.br_taken = br_taken_q;
    assign bus.illegal  = illegal_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Scoreboard bench for alu_issue_seq: a combinational ALU closes the loop, the driver
// pushes expected pulses from a behavioural model, and a monitor pops and compares them.
module tb_alu_issue_seq;
    import alu_pkg::*;

    localparam int W       = 32;
    localparam int MUL_LAT = 3;

    typedef struct {
        logic [2:0]  kind;   // {wb, br, illegal}
        logic [31:0] data;
        logic        en;
        logic        taken;
        logic [1:0]  flg;
        int          due;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_fail;
    logic [1:0] mflags;
    exp_t exp_q[$];
    logic [31:0] alu_r_s;

    alu_issue_seq_if #(.W(W)) bus ();

    alu_issue_seq #(.W(W), .MUL_LAT(MUL_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Environment ALU
    always_comb begin
        case (bus.alu_func)
            4'b0000: alu_r_s = bus.alu_a & bus.alu_b;
            4'b0001: alu_r_s = bus.alu_a | bus.alu_b;
            4'b0010: alu_r_s = bus.alu_a ^ bus.alu_b;
            4'b0011: alu_r_s = bus.alu_a + bus.alu_b;
            4'b0100: alu_r_s = bus.alu_a - bus.alu_b;
            4'b0101: alu_r_s = bus.alu_a - bus.alu_b;
            4'b0110: alu_r_s = ~bus.alu_a;
            4'b0111: alu_r_s = bus.alu_a << 16;
            4'b1000: alu_r_s = bus.alu_a * bus.alu_b;
            default: alu_r_s = 32'd0;
        endcase
    end
    assign bus.alu_result = alu_r_s;
    assign bus.alu_flags  = (alu_r_s == 32'd0) ? 2'b01 : (alu_r_s[31] ? 2'b10 : 2'b00);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] wide;
        case (op)
            OP_AND:         wide = {32'd0, a & b};
            OP_OR:          wide = {32'd0, a | b};
            OP_XOR:         wide = {32'd0, a ^ b};
            OP_ADD:         wide = {32'd0, a} + {32'd0, b};
            OP_SUB, OP_CMP: wide = {32'd0, a} - {32'd0, b};
            OP_NOT:         wide = {32'd0, ~a};
            OP_SHL16:       wide = {32'd0, a} * 64'd65536;
            OP_MUL:         wide = {32'd0, a} * {32'd0, b};
            default:        wide = 64'd0;
        endcase
        return wide[31:0];
    endfunction

    // Drive one op, hold it until accepted, and record the expected response
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int   guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        while (bus.in_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", {63'd0, bus.in_ready}, 64'd1);
        if (bus.in_ready === 1'b1) begin
            e.data  = ref_result(op, a, b);
            e.en    = 1'b0;
            e.taken = 1'b0;
            if (op <= 4'd8) begin
                e.kind = 3'b100;
                e.en   = (op != OP_CMP);
                e.due  = cyc + ((op == OP_MUL) ? 2 + MUL_LAT : 2);
                if (op == OP_CMP) begin
                    if (a == b)                   mflags = 2'b01;
                    else if (e.data[31] == 1'b1)  mflags = 2'b10;
                    else                          mflags = 2'b00;
                end
            end else if (op <= 4'd11) begin
                e.kind  = 3'b010;
                e.due   = cyc + 1;
                e.taken = (op == OP_BEQ && mflags == 2'b01) ||
                          (op == OP_BLT && mflags == 2'b10) ||
                          (op == OP_BGT && mflags == 2'b00);
            end else begin
                e.kind = 3'b001;
                e.due  = cyc + 1;
            end
            e.flg = mflags;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    // Monitor: compare every presented pulse against the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (bus.wb_valid || bus.br_valid || bus.illegal) begin
                    check("in_ready_low_at_pulse", {63'd0, bus.in_ready}, 64'd0);
                    check("alu_func_nop_at_pulse", {60'd0, bus.alu_func}, 64'hF);
                    if (exp_q.size() == 0) begin
                        check("unexpected_pulse", {61'd0, bus.wb_valid, bus.br_valid, bus.illegal}, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("pulse_kind", {61'd0, bus.wb_valid, bus.br_valid, bus.illegal}, {61'd0, e.kind});
                        check("pulse_cycle", 64'(cyc), 64'(e.due));
                        check("flags", {62'd0, bus.flags}, {62'd0, e.flg});
                        if (e.kind == 3'b100) begin
                            check("wb_en", {63'd0, bus.wb_en}, {63'd0, e.en});
                            check("wb_data", {32'd0, bus.wb_data}, {32'd0, e.data});
                        end else if (e.kind == 3'b010) begin
                            check("br_taken", {63'd0, bus.br_taken}, {63'd0, e.taken});
                        end
                    end
                end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
                    check("pulse_missing_due", 64'(cyc), 64'(exp_q[0].due));
                    void'(exp_q.pop_front());
                end else if (bus.in_ready === 1'b1) begin
                    check("idle_alu_func", {60'd0, bus.alu_func}, 64'hF);
                end
            end
        end
    end

    initial begin
        cyc    = 0;
        n_cmp  = 0;
        n_fail = 0;
        mflags = 2'b00;
        rst_n  = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_op    = 4'd0;
        bus.in_a     = 32'd0;
        bus.in_b     = 32'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("rst_alu_func", {60'd0, bus.alu_func}, 64'hF);
        check("rst_alu_ab", {bus.alu_a, bus.alu_b}, 64'd0);
        check("rst_wb_data", {32'd0, bus.wb_data}, 64'd0);
        check("rst_flags", {62'd0, bus.flags}, 64'd0);
        check("rst_pulses", {60'd0, bus.wb_valid, bus.br_valid, bus.illegal, bus.wb_en}, 64'd0);

        issue(OP_ADD, 32'd5, 32'd7);
        issue(OP_CMP, 32'd3, 32'd3);
        issue(OP_BEQ, 32'd0, 32'd0);
        issue(OP_CMP, 32'd2, 32'd9);
        issue(OP_BGT, 32'd0, 32'd0);
        issue(OP_BLT, 32'd0, 32'd0);
        issue(OP_MUL, 32'h0001_0000, 32'h0001_0000);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("mul_in_ready_low", {63'd0, bus.in_ready}, 64'd0);
        end
        issue(4'b1100, 32'h1234, 32'h5678);

        // Reset while a MUL is in MUL_WAIT: the op is dropped
        issue(OP_MUL, 32'd6, 32'd7);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        mflags = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midop_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("midop_rst_flags", {62'd0, bus.flags}, 64'd0);
        check("midop_rst_no_wb", {63'd0, bus.wb_valid}, 64'd0);
        repeat (6) @(negedge clk);

        for (int i = 0; i < 300; i++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 4) == 0) begin
                a = 32'($urandom_range(0, 8));
                b = 32'($urandom_range(0, 8));
            end
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            issue(op, a, b);
        end

        repeat (20) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
